// File: rtl/nes_clk_pkg.sv
// nes_clk_pkg: shared mode/state types and classic NES divisors for the clock-enable generator
package nes_clk_pkg;
    typedef enum logic [1:0] {MODE_RUN, MODE_HALT, MODE_STEP, MODE_RSVD} clk_mode_e;
    typedef enum logic [1:0] {S_RUN, S_HALT, S_STEP} clk_state_e;
    localparam int NES_DIV_CPU = 12;
    localparam int NES_DIV_PPU = 4;
endpackage

// File: rtl/nes_clk_enable_gen_ch.sv
// nes_clk_div_ch: one enable channel with phase counter and shadowed divisor
module nes_clk_div_ch import nes_clk_pkg::*; #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             adv,
    input  logic             sync,
    input  logic             load,
    input  logic [CNT_W-1:0] div,
    output logic             fire
);
    logic [CNT_W-1:0] cnt, shadow, act, last;
    // terminal count, with a zero divisor behaving like 1
    always_comb begin
        last = (act == '0) ? '0 : act - CNT_W'(1);
        fire = adv && (cnt == last);
    end
    // counter; a new divisor takes effect at the wrap, or at once alongside a re-sync
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt    <= '0;
            shadow <= CNT_W'(1);
            act    <= CNT_W'(1);
        end else if (sync) begin
            cnt <= '0;
            if (load) begin
                shadow <= div;
                act    <= div;
            end
        end else begin
            if (load) shadow <= div;
            if (fire) begin
                cnt <= '0;
                act <= shadow;
            end else if (adv) begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end
endmodule

// File: rtl/nes_clk_enable_gen.sv
// nes_clk_enable_gen: run/halt/step controller driving per-channel clock enables
module nes_clk_enable_gen import nes_clk_pkg::*; #(
    parameter int NUM_CH = 3,
    parameter int CNT_W  = 8,
    parameter int REF_CH = 0,
    parameter int MCNT_W = 32
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [1:0]              mode_i,
    input  logic                    step_i,
    input  logic                    sync_i,
    input  logic                    load_i,
    input  logic [NUM_CH*CNT_W-1:0] div_i,
    output logic [NUM_CH-1:0]       ce_o,
    output logic                    advancing_o,
    output logic                    busy_o,
    output logic [MCNT_W-1:0]       mcycle_o
);
    clk_state_e        state_q, state_d;
    clk_mode_e         mode;
    logic              adv;
    logic [NUM_CH-1:0] fire;
    assign mode = clk_mode_e'(mode_i);
    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        nes_clk_div_ch #(.CNT_W(CNT_W)) u_ch (
            .clk  (clk),
            .rst_n(rst_n),
            .adv  (adv),
            .sync (sync_i),
            .load (load_i),
            .div  (div_i[c*CNT_W +: CNT_W]),
            .fire (fire[c])
        );
    end
    // next state; reserved mode behaves as halt and a re-sync swallows a step request
    always_comb begin
        adv     = (state_q == S_RUN || state_q == S_STEP) && !sync_i;
        state_d = state_q;
        case (state_q)
            S_RUN:   state_d = (mode == MODE_RUN) ? S_RUN : S_HALT;
            S_STEP:  state_d = (mode == MODE_RUN) ? S_RUN : (fire[REF_CH] ? S_HALT : S_STEP);
            default: state_d = (mode == MODE_RUN) ? S_RUN :
                               ((mode == MODE_STEP && step_i && !sync_i) ? S_STEP : S_HALT);
        endcase
    end
    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_HALT;
        else        state_q <= state_d;
    end
    // registered enables, status flags and advance counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ce_o        <= '0;
            advancing_o <= 1'b0;
            busy_o      <= 1'b0;
            mcycle_o    <= '0;
        end else begin
            ce_o        <= fire;
            advancing_o <= adv;
            busy_o      <= (state_d == S_STEP);
            mcycle_o    <= mcycle_o + MCNT_W'(adv);
        end
    end
endmodule

// File: tb/tb_nes_clk_enable_gen.sv
// tb_nes_clk_enable_gen: table rows plus corner sequences against a cycle scoreboard
module tb_nes_clk_enable_gen;
    import nes_clk_pkg::*;
    localparam int CW = 8;
    logic clk = 1'b0, rst_n = 1'b1;
    logic [1:0] mode = 2'b01;
    logic step = 1'b0, sync = 1'b0, load = 1'b0;
    logic [2*CW-1:0] div = '0;
    logic [1:0] ce, ce4;
    logic adv_o, busy, adv4, busy4;
    logic [31:0] mc;
    logic [3:0] mc4;
    always #5 clk = ~clk;

    nes_clk_enable_gen #(.NUM_CH(2), .CNT_W(CW), .REF_CH(0), .MCNT_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .mode_i(mode), .step_i(step), .sync_i(sync), .load_i(load),
        .div_i(div), .ce_o(ce), .advancing_o(adv_o), .busy_o(busy), .mcycle_o(mc));
    nes_clk_enable_gen #(.NUM_CH(2), .CNT_W(CW), .REF_CH(0), .MCNT_W(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .mode_i(mode), .step_i(step), .sync_i(sync), .load_i(load),
        .div_i(div), .ce_o(ce4), .advancing_o(adv4), .busy_o(busy4), .mcycle_o(mc4));

    typedef struct packed {logic [1:0] ce; logic adv; logic busy; logic [31:0] mc;} exp_t;
    typedef struct {logic [1:0] mode; logic ls; int d0, d1, n, e0, e1, emc, per0; logic coin;} row_t;
    exp_t sb[$];
    row_t rows[5];
    clk_state_e ms;
    int mcnt[2], mact[2], msh[2];
    logic [31:0] mmc, s;
    int checks = 0, errors = 0, tn, nbusy, nco;
    int p0[$], p1[$];

    task automatic chk(input string name, input logic [63:0] a, input logic [63:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, a, e, $time);
        end
    endtask

    task automatic model_reset();
        ms = S_HALT;
        mmc = '0;
        for (int c = 0; c < 2; c++) begin
            mcnt[c] = 0; mact[c] = 1; msh[c] = 1;
        end
    endtask

    task automatic mark();
        p0.delete(); p1.delete();
        tn = 0; nbusy = 0; nco = 0;
    endtask

    task automatic tick(input logic [1:0] m, input logic st, input logic sy, input logic ld,
                        input int d0, input int d1);
        exp_t e;
        logic a;
        logic [1:0] f;
        clk_state_e ns;
        int dv[2];
        int per;
        dv[0] = d0; dv[1] = d1;
        mode = m; step = st; sync = sy; load = ld;
        div = {CW'(d1), CW'(d0)};
        a = (ms == S_RUN || ms == S_STEP) && !sy;
        for (int c = 0; c < 2; c++) begin
            per = (mact[c] < 2) ? 1 : mact[c];
            f[c] = a && (mcnt[c] == per - 1);
        end
        ns = ms;
        if (ms == S_HALT) begin
            if (m == 2'b00) ns = S_RUN;
            else if (m == 2'b10 && st && !sy) ns = S_STEP;
        end else if (ms == S_RUN) begin
            if (m != 2'b00) ns = S_HALT;
        end else begin
            if (m == 2'b00) ns = S_RUN;
            else if (f[0]) ns = S_HALT;
        end
        for (int c = 0; c < 2; c++) begin
            if (sy) begin
                mcnt[c] = 0;
                if (ld) begin mact[c] = dv[c]; msh[c] = dv[c]; end
            end else begin
                if (f[c]) begin mcnt[c] = 0; mact[c] = msh[c]; end
                else if (a) mcnt[c]++;
                if (ld) msh[c] = dv[c];
            end
        end
        mmc = mmc + 32'(a);
        ms = ns;
        sb.push_back(exp_t'{f, a, ns == S_STEP, mmc});
        @(posedge clk);
        #1;
        e = sb.pop_front();
        chk("ce", ce, e.ce);
        chk("advancing", adv_o, e.adv);
        chk("busy", busy, e.busy);
        chk("mcycle", mc, e.mc);
        chk("ce_w4", ce4, e.ce);
        chk("adv_w4", adv4, e.adv);
        chk("busy_w4", busy4, e.busy);
        chk("mcycle_w4", mc4, e.mc[3:0]);
        tn++;
        if (ce[0]) p0.push_back(tn);
        if (ce[1]) p1.push_back(tn);
        if (busy) nbusy++;
        if (ce[0] && !ce[1]) nco++;
    endtask

    initial begin
        rows[0] = '{2'b00, 1'b1, 12, 4, 49, 4, 12, 48, 12, 1'b1};
        rows[1] = '{2'b00, 1'b1,  0, 1, 11, 10, 10, 10, 1, 1'b1};
        rows[2] = '{2'b01, 1'b0,  1, 1, 10, 1, 1, 1, 0, 1'b0};
        rows[3] = '{2'b00, 1'b1,  3, 5, 16, 5, 3, 15, 3, 1'b0};
        rows[4] = '{2'b00, 1'b1, 12, 4, 31, 2, 7, 30, 12, 1'b1};
        model_reset();
        #1 rst_n = 1'b0;
        #2;
        chk("reset_ce", ce, 2'b00);
        chk("reset_adv", adv_o, 1'b0);
        chk("reset_busy", busy, 1'b0);
        chk("reset_mcycle", mc, 32'd0);
        #9 rst_n = 1'b1;

        for (int i = 0; i < 5; i++) begin
            s = mmc;
            mark();
            tick(rows[i].mode, 1'b0, rows[i].ls, rows[i].ls, rows[i].d0, rows[i].d1);
            for (int k = 1; k < rows[i].n; k++)
                tick(rows[i].mode, 1'b0, 1'b0, 1'b0, rows[i].d0, rows[i].d1);
            chk("row_ce0_count", p0.size(), rows[i].e0);
            chk("row_ce1_count", p1.size(), rows[i].e1);
            chk("row_mcycle_delta", mc - s, rows[i].emc);
            if (rows[i].per0 != 0)
                for (int k = 1; k < p0.size(); k++)
                    chk("row_ce0_spacing", p0[k] - p0[k-1], rows[i].per0);
            if (rows[i].coin) chk("row_ce_coincide", nco, 0);
        end

        // divisor change mid-period: old period completes, then period 3
        mark();
        tick(2'b00, 1'b0, 1'b1, 1'b1, 12, 4);
        repeat (5) tick(2'b00, 1'b0, 1'b0, 1'b0, 12, 4);
        tick(2'b00, 1'b0, 1'b0, 1'b1, 3, 4);
        repeat (14) tick(2'b00, 1'b0, 1'b0, 1'b0, 3, 4);
        chk("reload_count", p0.size(), 3);
        if (p0.size() == 3) begin
            chk("reload_first", p0[0], 13);
            chk("reload_second", p0[1], 16);
            chk("reload_third", p0[2], 19);
        end

        // single step from cnt0=7
        tick(2'b00, 1'b0, 1'b1, 1'b1, 12, 4);
        repeat (6) tick(2'b00, 1'b0, 1'b0, 1'b0, 12, 4);
        tick(2'b01, 1'b0, 1'b0, 1'b0, 12, 4);
        tick(2'b10, 1'b0, 1'b0, 1'b0, 12, 4);
        s = mmc;
        mark();
        tick(2'b10, 1'b1, 1'b0, 1'b0, 12, 4);
        repeat (8) tick(2'b10, 1'b0, 1'b0, 1'b0, 12, 4);
        chk("step_busy_cycles", nbusy, 5);
        chk("step_ce0_count", p0.size(), 1);
        if (p0.size() == 1) chk("step_ce0_pos", p0[0], 6);
        chk("step_ce1_at_most_2", p1.size() <= 2, 1'b1);
        chk("step_mcycle_delta", mc - s, 5);
        tick(2'b10, 1'b1, 1'b1, 1'b0, 12, 4);
        chk("sync_drops_step", busy, 1'b0);
        tick(2'b01, 1'b1, 1'b0, 1'b0, 12, 4);
        chk("step_ignored_in_halt_mode", busy, 1'b0);

        // re-sync mid-run at cnt {9,1}
        tick(2'b00, 1'b0, 1'b1, 1'b1, 12, 4);
        repeat (9) tick(2'b00, 1'b0, 1'b0, 1'b0, 12, 4);
        s = mmc;
        tick(2'b00, 1'b0, 1'b1, 1'b0, 12, 4);
        chk("sync_no_ce", ce, 2'b00);
        chk("sync_mcycle_kept", mc, s);
        mark();
        repeat (12) tick(2'b00, 1'b0, 1'b0, 1'b0, 12, 4);
        chk("sync_ce0_count", p0.size(), 1);
        if (p0.size() == 1) chk("sync_ce0_pos", p0[0], 12);
        chk("sync_ce1_count", p1.size(), 3);
        if (p1.size() == 3) chk("sync_ce1_first", p1[0], 4);

        // asynchronous reset while stepping
        tick(2'b00, 1'b0, 1'b1, 1'b1, 12, 4);
        repeat (3) tick(2'b00, 1'b0, 1'b0, 1'b0, 12, 4);
        tick(2'b01, 1'b0, 1'b0, 1'b0, 12, 4);
        tick(2'b10, 1'b1, 1'b0, 1'b0, 12, 4);
        tick(2'b10, 1'b0, 1'b0, 1'b0, 12, 4);
        #3 rst_n = 1'b0;
        #1;
        chk("async_rst_ce", ce, 2'b00);
        chk("async_rst_adv", adv_o, 1'b0);
        chk("async_rst_busy", busy, 1'b0);
        chk("async_rst_mcycle", mc, 32'd0);
        chk("async_rst_mcycle_w4", mc4, 4'd0);
        model_reset();
        #2 rst_n = 1'b1;
        mark();
        repeat (10) tick(2'b10, 1'b0, 1'b0, 1'b0, 12, 4);
        chk("post_rst_no_ce0", p0.size(), 0);
        chk("post_rst_no_ce1", p1.size(), 0);
        mark();
        repeat (5) tick(2'b00, 1'b0, 1'b0, 1'b0, 12, 4);
        chk("post_rst_run_ce0", p0.size(), 4);

        // narrow advance counter wraps modulo 16
        #3 rst_n = 1'b0;
        model_reset();
        #2 rst_n = 1'b1;
        tick(2'b00, 1'b0, 1'b1, 1'b1, 3, 5);
        mark();
        repeat (20) tick(2'b00, 1'b0, 1'b0, 1'b0, 3, 5);
        chk("wrap_mcycle_w4", mc4, 4'd4);
        chk("wrap_mcycle_w32", mc, 32'd20);
        chk("wrap_ce0_count", p0.size(), 6);
        chk("wrap_ce1_count", p1.size(), 4);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
